legofpga_pkt_gen: RTL and testbench

Synthesizable Ethernet frame generator driving the 64-bit AXI-Stream TX interface of the QSFP 25G MAC. It is the transmit-side counterpart of the MAC loopback monitor: once `mac_ready` is high it emits a programmed number of frames of programmed length, with a deterministic, sequence-tagged payload that the RX checker can verify after GT loopback. It sits between the system control logic and the MAC TX AXIS port in `legofpga_mac_qsfp`.

---
 rtl/legofpga_pkt_gen.sv | 172 +++++++++++++++++
 tb/tb_legofpga_pkt_gen.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legofpga_pkt_gen.sv
// Ethernet frame generator for the 64-bit AXIS TX port of the QSFP 25G MAC.
// Optional: define PKT_GEN_CONTINUOUS_EN to make pkt_count == 0 an unbounded run.
module legofpga_pkt_gen #(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0000_0A35_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        sys_reset,
  input  logic        mac_ready,
  input  logic        start,
  input  logic        stop,
  input  logic [13:0] pkt_len,
  input  logic [31:0] pkt_count,
  input  logic [7:0]  ifg_cycles,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tvalid,
  output logic        tx_tlast,
  output logic        tx_tuser,
  input  logic        tx_tready,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent
);

  typedef enum logic [1:0] {StIdle, StWaitReady, StSend, StGap} state_e;

  state_e      state_q;
  logic [10:0] beats_q;
  logic [10:0] beat_q;
  logic [7:0]  last_keep_q;
  logic [31:0] target_q;
  logic [31:0] seq_q;
  logic [7:0]  ifg_q;
  logic [7:0]  gap_q;

  logic [13:0] len_clamp;
  logic [10:0] len_beats;
  logic [7:0]  len_keep;
  logic [10:0] nxt_beat;
  logic        nxt_last;
  logic [7:0]  nxt_keep;
  logic [63:0] nxt_data;
  logic        run_done;

  assign tx_tuser = 1'b0;

  function automatic logic [7:0] frame_byte(logic [13:0] k, logic [31:0] seq);
    int unsigned kk;
    logic [7:0]  b;
    kk = 32'(k);
    if (kk < 6)       b = 8'(DST_MAC >> (8 * (5 - kk)));
    else if (kk < 12) b = 8'(SRC_MAC >> (8 * (11 - kk)));
    else if (kk < 14) b = 8'(ETHERTYPE >> (8 * (13 - kk)));
    else if (kk < 18) b = 8'(seq >> (8 * (17 - kk)));
    else              b = k[7:0] ^ seq[7:0];
    return b;
  endfunction

  always_comb begin
    if (pkt_len < 14'd64)        len_clamp = 14'd64;
    else if (pkt_len > 14'd9600) len_clamp = 14'd9600;
    else                         len_clamp = pkt_len;
    len_beats = 11'((len_clamp + 14'd7) >> 3);
    len_keep  = (len_clamp[2:0] == 3'd0) ? 8'hFF : (8'd1 << len_clamp[2:0]) - 8'd1;
  end

  // Data for the beat that will be presented after the next accepted handshake.
  always_comb begin
    nxt_beat = (state_q == StSend) ? beat_q + 11'd1 : 11'd0;
    nxt_last = (nxt_beat == beats_q - 11'd1);
    nxt_keep = nxt_last ? last_keep_q : 8'hFF;
    for (int i = 0; i < 8; i++) begin
      nxt_data[8*i +: 8] = nxt_keep[i] ? frame_byte({nxt_beat, 3'(i)}, seq_q) : 8'h00;
    end
  end

`ifdef PKT_GEN_CONTINUOUS_EN
  assign run_done = (target_q != 32'd0) && (frames_sent == target_q);
`else
  assign run_done = (frames_sent == target_q);
`endif

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q     <= StIdle;
      beats_q     <= '0;
      beat_q      <= '0;
      last_keep_q <= '0;
      target_q    <= '0;
      seq_q       <= '0;
      ifg_q       <= '0;
      gap_q       <= '0;
      tx_tdata    <= '0;
      tx_tkeep    <= '0;
      tx_tvalid   <= 1'b0;
      tx_tlast    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            beats_q     <= len_beats;
            last_keep_q <= len_keep;
            target_q    <= pkt_count;
            ifg_q       <= ifg_cycles;
            seq_q       <= '0;
            frames_sent <= '0;
`ifdef PKT_GEN_CONTINUOUS_EN
            state_q     <= StWaitReady;
            busy        <= 1'b1;
`else
            if (pkt_count == 32'd0) begin
              done <= 1'b1;
            end else begin
              state_q <= StWaitReady;
              busy    <= 1'b1;
            end
`endif
          end
        end
        StWaitReady: begin
          if (stop || run_done) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (mac_ready) begin
            state_q   <= StSend;
            beat_q    <= '0;
            tx_tvalid <= 1'b1;
            tx_tdata  <= nxt_data;
            tx_tkeep  <= nxt_keep;
            tx_tlast  <= nxt_last;
          end
        end
        StSend: begin
          if (tx_tready) begin
            if (tx_tlast) begin
              tx_tvalid   <= 1'b0;
              tx_tlast    <= 1'b0;
              tx_tdata    <= '0;
              tx_tkeep    <= '0;
              frames_sent <= frames_sent + 32'd1;
              seq_q       <= seq_q + 32'd1;
              if (ifg_q != 8'd0) begin
                state_q <= StGap;
                gap_q   <= ifg_q - 8'd1;
              end else begin
                state_q <= StWaitReady;
              end
            end else begin
              beat_q   <= nxt_beat;
              tx_tdata <= nxt_data;
              tx_tkeep <= nxt_keep;
              tx_tlast <= nxt_last;
            end
          end
        end
        StGap: begin
          if (gap_q == 8'd0) state_q <= StWaitReady;
          else               gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_legofpga_pkt_gen.sv
// Randomised self-checking bench for legofpga_pkt_gen against a byte-stream frame model.
module tb_legofpga_pkt_gen;

  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0000_0A35_0001;
  localparam logic [15:0] ETY = 16'h88B5;

  logic        clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        mac_ready = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [13:0] pkt_len = '0;
  logic [31:0] pkt_count = '0;
  logic [7:0]  ifg_cycles = '0;
  logic        tx_tready = 1'b1;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tvalid, tx_tlast, tx_tuser, busy, done;
  logic [31:0] frames_sent;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit stall_en = 1'b0;

  logic [63:0] acc_data[$];
  logic [7:0]  acc_keep[$];
  bit          acc_last[$];
  int          acc_cyc[$];
  int          vrise[$];
  int          stall_viol = 0;
  bit          prev_valid = 1'b0;
  bit          prev_stalled = 1'b0;
  logic [63:0] pd;
  logic [7:0]  pk;
  logic        pl;

  logic [7:0]  rx_bytes[$];
  logic [7:0]  exp_bytes[$];
  int          rx_lens[$];
  int          exp_lens[$];
  int          keep_bad;

  legofpga_pkt_gen dut (
    .clk(clk), .sys_reset(sys_reset), .mac_ready(mac_ready), .start(start), .stop(stop),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .ifg_cycles(ifg_cycles),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tuser(tx_tuser), .tx_tready(tx_tready), .busy(busy), .done(done),
    .frames_sent(frames_sent)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    tx_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Passive monitor: records accepted beats, tvalid rises and stall-stability breaks.
  initial forever begin
    @(negedge clk);
    if (prev_stalled && (tx_tvalid !== 1'b1 || tx_tdata !== pd || tx_tkeep !== pk ||
                         tx_tlast !== pl)) stall_viol++;
    if (tx_tvalid === 1'b1 && !prev_valid) vrise.push_back(cyc);
    if (tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
      acc_data.push_back(tx_tdata);
      acc_keep.push_back(tx_tkeep);
      acc_last.push_back(tx_tlast);
      acc_cyc.push_back(cyc);
    end
    prev_valid   = (tx_tvalid === 1'b1);
    prev_stalled = (tx_tvalid === 1'b1) && (tx_tready !== 1'b1);
    pd = tx_tdata; pk = tx_tkeep; pl = tx_tlast;
  end

  function automatic int clamp_len(int len);
    if (len < 64) return 64;
    if (len > 9600) return 9600;
    return len;
  endfunction

  task automatic build_expected(input int len, input int count);
    int l;
    exp_bytes.delete(); exp_lens.delete();
    l = clamp_len(len);
    for (int f = 0; f < count; f++) begin
      for (int j = 0; j < 6; j++) exp_bytes.push_back(8'(DST >> (40 - 8 * j)));
      for (int j = 0; j < 6; j++) exp_bytes.push_back(8'(SRC >> (40 - 8 * j)));
      exp_bytes.push_back(ETY[15:8]);
      exp_bytes.push_back(ETY[7:0]);
      for (int j = 0; j < 4; j++) exp_bytes.push_back(8'(f >> (24 - 8 * j)));
      for (int k = 18; k < l; k++) exp_bytes.push_back(8'(k) ^ 8'(f));
      exp_lens.push_back(l);
    end
  endtask

  // Rebuilds received frames from the accepted beats.
  task automatic collect();
    int cur;
    logic [7:0] k;
    rx_bytes.delete(); rx_lens.delete(); keep_bad = 0; cur = 0;
    for (int b = 0; b < acc_data.size(); b++) begin
      k = acc_keep[b];
      if (k == 8'h00 || ((k & (k + 8'd1)) != 8'h00)) keep_bad++;
      if (!acc_last[b] && k != 8'hFF) keep_bad++;
      for (int i = 0; i < 8; i++) begin
        if (k[i]) begin rx_bytes.push_back(acc_data[b][8*i +: 8]); cur++; end
      end
      if (acc_last[b]) begin rx_lens.push_back(cur); cur = 0; end
    end
  endtask

  function automatic int first_diff();
    if (rx_lens.size() != exp_lens.size()) return -3;
    for (int i = 0; i < rx_lens.size(); i++) if (rx_lens[i] != exp_lens[i]) return -3;
    if (rx_bytes.size() != exp_bytes.size()) return -2;
    for (int i = 0; i < rx_bytes.size(); i++) if (rx_bytes[i] !== exp_bytes[i]) return i;
    return -1;
  endfunction

  task automatic clear_mon();
    acc_data.delete(); acc_keep.delete(); acc_last.delete(); acc_cyc.delete();
    vrise.delete();
  endtask

  task automatic pulse_start(input int len, input int count, input int ifg, output int n);
    @(posedge clk); #1;
    clear_mon();
    pkt_len = 14'(len); pkt_count = count; ifg_cycles = 8'(ifg); start = 1'b1; n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dc);
    ok = 1'b0; dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; dc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({tx_tvalid, tx_tlast, tx_tuser, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {tx_tvalid, tx_tlast, tx_tuser, busy, done});
    end
    n_tests++;
    if (tx_tdata !== 64'h0 || tx_tkeep !== 8'h0 || frames_sent !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", tx_tdata, tx_tkeep, frames_sent);
    end
    @(posedge clk); #1; sys_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tx_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got valid=%b busy=%b want 0 0", tx_tvalid, busy);
    end
  endtask

  task automatic test_basic();
    int n, dc, first, d;
    bit ok;
    pulse_start(64, 1, 0, n);
    wait_done(200, ok, dc);
    collect(); build_expected(64, 1);
    first = (vrise.size() > 0) ? vrise[0] : -1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no done want done"); end
    n_tests++;
    if (first != n + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", first, n + 2); end
    n_tests++;
    if (acc_data.size() != 8) begin
      n_fail++; $display("FAIL basic_beats: got %0d want 8", acc_data.size());
    end else begin
      n_tests++;
      if (acc_data[0] !== 64'h0000_FFFF_FFFF_FFFF) begin
        n_fail++; $display("FAIL basic_beat0: got %h want 0000ffffffffffff", acc_data[0]);
      end
      n_tests++;
      if (acc_last[7] !== 1'b1 || acc_keep[7] !== 8'hFF || acc_last[6] !== 1'b0) begin
        n_fail++; $display("FAIL basic_last: got last=%b keep=%h want 1 ff", acc_last[7], acc_keep[7]);
      end
      n_tests++;
      if (dc != acc_cyc[7] + 2) begin
        n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, acc_cyc[7] + 2);
      end
    end
    n_tests++;
    if (frames_sent !== 32'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: got sent=%0d busy=%b want 1 0", frames_sent, busy);
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin n_fail++; $display("FAIL basic_stream: got diff at %0d want none", d); end
  endtask

`ifndef PKT_GEN_CONTINUOUS_EN
  task automatic test_zero_count();
    int n, dc;
    bit ok, b;
    pulse_start(100, 0, 0, n);
    wait_done(5, ok, dc);
    b = busy;
    repeat (6) @(negedge clk);
    n_tests++;
    if (!ok || dc != n + 1) begin n_fail++; $display("FAIL zero_done: got cyc %0d want %0d", dc, n + 1); end
    n_tests++;
    if (b !== 1'b0 || frames_sent !== 32'd0 || vrise.size() != 0) begin
      n_fail++; $display("FAIL zero_quiet: got busy=%b sent=%0d rises=%0d want 0 0 0",
                         b, frames_sent, vrise.size());
    end
  endtask
`endif

  task automatic test_len_clamp();
    int n, dc, d;
    bit ok;
    logic [31:0] s1;
    pulse_start(61, 2, 0, n);
    wait_done(200, ok, dc);
    collect(); build_expected(61, 2);
    d = first_diff();
    n_tests++;
    if (!ok || acc_data.size() != 16 || d != -1) begin
      n_fail++; $display("FAIL clamp_low: got beats=%0d diff=%0d want 16 -1", acc_data.size(), d);
    end
    pulse_start(67, 2, 0, n);
    wait_done(200, ok, dc);
    collect(); build_expected(67, 2);
    d = first_diff();
    n_tests++;
    if (!ok || d != -1 || keep_bad != 0) begin
      n_fail++; $display("FAIL len67_stream: got diff=%0d keepbad=%0d want -1 0", d, keep_bad);
    end
    n_tests++;
    if (acc_data.size() != 18) begin
      n_fail++; $display("FAIL len67_beats: got %0d want 18", acc_data.size());
    end else begin
      n_tests++;
      if (acc_keep[8] !== 8'h07 || acc_last[8] !== 1'b1) begin
        n_fail++; $display("FAIL len67_lastkeep: got %h/%b want 07/1", acc_keep[8], acc_last[8]);
      end
      n_tests++;
      if (acc_data[1][63:48] !== 16'h0000) begin
        n_fail++; $display("FAIL len67_beat1_lanes67: got %h want 0000", acc_data[1][63:48]);
      end
      n_tests++;
      if (vrise.size() < 2 || vrise[1] != acc_cyc[8] + 2) begin
        n_fail++; $display("FAIL b2b_gap: got rises=%0d want second at %0d", vrise.size(), acc_cyc[8] + 2);
      end
    end
    s1 = (rx_bytes.size() >= 85) ? {rx_bytes[81], rx_bytes[82], rx_bytes[83], rx_bytes[84]} : 'x;
    n_tests++;
    if (s1 !== 32'h0000_0001) begin n_fail++; $display("FAIL len67_seq1: got %h want 00000001", s1); end
  endtask

  task automatic test_stalls();
    int n, dc, d;
    bit ok;
    logic [7:0] b100;
    stall_viol = 0; stall_en = 1'b1;
    pulse_start(1500, 4, 0, n);
    wait_done(8000, ok, dc);
    stall_en = 1'b0;
    collect(); build_expected(1500, 4);
    d = first_diff();
    b100 = (rx_bytes.size() > 3100) ? rx_bytes[3100] : 'x;
    n_tests++;
    if (!ok || frames_sent !== 32'd4) begin
      n_fail++; $display("FAIL stall_count: got sent=%0d done=%b want 4 1", frames_sent, ok);
    end
    n_tests++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d breaks want 0", stall_viol); end
    n_tests++;
    if (d != -1 || keep_bad != 0) begin
      n_fail++; $display("FAIL stall_stream: got diff=%0d keepbad=%0d want -1 0", d, keep_bad);
    end
    n_tests++;
    if (b100 !== 8'h66) begin n_fail++; $display("FAIL stall_byte100: got %h want 66", b100); end
  endtask

  task automatic test_ifg();
    int n, dc;
    bit ok;
    int lastc[$];
    pulse_start(64, 3, 5, n);
    wait_done(300, ok, dc);
    for (int i = 0; i < acc_last.size(); i++) if (acc_last[i]) lastc.push_back(acc_cyc[i]);
    n_tests++;
    if (!ok || vrise.size() != 3 || lastc.size() != 3) begin
      n_fail++; $display("FAIL ifg_frames: got rises=%0d lasts=%0d want 3 3", vrise.size(), lastc.size());
    end else begin
      n_tests++;
      if (vrise[1] != lastc[0] + 7 || vrise[2] != lastc[1] + 7) begin
        n_fail++; $display("FAIL ifg_spacing: got %0d %0d want %0d %0d",
                           vrise[1], vrise[2], lastc[0] + 7, lastc[1] + 7);
      end
    end
  endtask

  task automatic test_mac_ready();
    int n, dc, r, first, d;
    bit ok;
    @(posedge clk); #1; mac_ready = 1'b0;
    pulse_start(200, 2, 0, n);
    while (cyc < n + 20) begin @(posedge clk); #1; end
    n_tests++;
    if (vrise.size() != 0) begin n_fail++; $display("FAIL mr_withheld: got %0d rises want 0", vrise.size()); end
    mac_ready = 1'b1; r = cyc;
    for (int i = 0; i < 50 && acc_data.size() < 4; i++) begin @(posedge clk); #1; end
    mac_ready = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    first = (vrise.size() > 0) ? vrise[0] : -1;
    n_tests++;
    if (first != r + 1) begin n_fail++; $display("FAIL mr_latency: got %0d want %0d", first, r + 1); end
    n_tests++;
    if (acc_data.size() != 25 || vrise.size() != 1 || frames_sent !== 32'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mr_drop: got beats=%0d rises=%0d sent=%0d busy=%b want 25 1 1 1",
                         acc_data.size(), vrise.size(), frames_sent, busy);
    end
    @(posedge clk); #1; mac_ready = 1'b1;
    wait_done(200, ok, dc);
    collect(); build_expected(200, 2);
    d = first_diff();
    n_tests++;
    if (!ok || frames_sent !== 32'd2 || d != -1) begin
      n_fail++; $display("FAIL mr_resume: got sent=%0d diff=%0d want 2 -1", frames_sent, d);
    end
  endtask

  task automatic test_stop();
    int n, dc, d;
    bit ok;
    pulse_start(64, 10, 0, n);
    for (int i = 0; i < 100 && acc_data.size() < 11; i++) begin @(posedge clk); #1; end
    stop = 1'b1;
    wait_done(100, ok, dc);
    collect(); build_expected(64, 2);
    d = first_diff();
    @(posedge clk); #1; stop = 1'b0;
    n_tests++;
    if (!ok || frames_sent !== 32'd2 || acc_data.size() != 16 || d != -1) begin
      n_fail++; $display("FAIL stop_mid: got done=%b sent=%0d beats=%0d diff=%0d want 1 2 16 -1",
                         ok, frames_sent, acc_data.size(), d);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_start(1500, 1, 0, n);
    for (int i = 0; i < 50 && acc_data.size() < 5; i++) begin @(posedge clk); #1; end
    sys_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (acc_data.size() < 5 || tx_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got beats=%0d valid=%b busy=%b want >=5 0 0",
                         acc_data.size(), tx_tvalid, busy);
    end
    @(posedge clk); #1; sys_reset = 1'b0;
  endtask

  task automatic test_random();
    int n, dc, d, len, count, ifg;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      len = (r == 2) ? 9700 : int'($urandom_range(20, 2000));
      count = (r == 2) ? 1 : int'($urandom_range(1, 3));
      ifg = int'($urandom_range(0, 3));
      stall_en = 1'($urandom_range(0, 1));
      pulse_start(len, count, ifg, n);
      wait_done(20000, ok, dc);
      stall_en = 1'b0;
      collect(); build_expected(len, count);
      d = first_diff();
      n_tests++;
      if (!ok || frames_sent !== 32'(count) || d != -1 || keep_bad != 0) begin
        n_fail++; $display("FAIL random_run len=%0d: got sent=%0d diff=%0d keepbad=%0d want %0d -1 0",
                           len, frames_sent, d, keep_bad, count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifndef PKT_GEN_CONTINUOUS_EN
    test_zero_count();
`endif
    test_len_clamp();
    test_stalls();
    test_ifg();
    test_mac_ready();
    test_stop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
